// File: rtl/alarm_ringer_if.sv
// Alarm-match and user-control bundle between the comparator/buttons and the ringer.
// The ringer attaches via the slave modport; the alarm/button side via master.
interface alarm_ringer_if;
  logic       tick_1hz;
  logic       on;
  logic       on_or_off;
  logic       stop_btn;
  logic       snooze_btn;
  logic       auto_rst;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_count;

  modport slave (
    input  tick_1hz, on, on_or_off, stop_btn, snooze_btn,
    output auto_rst, buzzer, ringing, snoozing, snooze_count
  );

  modport master (
    output tick_1hz, on, on_or_off, stop_btn, snooze_btn,
    input  auto_rst, buzzer, ringing, snoozing, snooze_count
  );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings, snoozes and clears the comparator latch, timed by the 1 Hz tick.
// Optional ALARM_ESCALATE_EN: continuous buzzer for the second half of each ring period.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for an enabled alarm match
// S_RING   | buzzer beeping at 1 Hz, ring timer running
// S_SNOOZE | silent, comparator held cleared, snooze timer running
// S_CLEAR  | comparator held cleared until the next second boundary
module alarm_ringer #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alarm_ringer_if.slave bus
);

  localparam int RW = $clog2(RING_SECONDS + 1);
  localparam int SW = $clog2(SNOOZE_SECONDS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [SW-1:0]   snz_cnt_q, snz_cnt_d;
  logic            beep_phase_q, beep_phase_d;
  logic [2:0]      snooze_count_q, snooze_count_d;
  logic            buzzer_q, buzzer_d;
  logic            ringing_q, ringing_d;
  logic            snoozing_q, snoozing_d;
  logic            auto_rst_q, auto_rst_d;
  logic            stop_req;

  // Disable and stop share the same exit and outrank everything else.
  assign stop_req = !bus.on_or_off || bus.stop_btn;

  always_comb begin
    state_d        = state_q;
    ring_cnt_d     = ring_cnt_q;
    snz_cnt_d      = snz_cnt_q;
    beep_phase_d   = beep_phase_q;
    snooze_count_d = snooze_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.on && bus.on_or_off) begin
          state_d        = S_RING;
          ring_cnt_d     = '0;
          beep_phase_d   = 1'b1;
          snooze_count_d = '0;
        end
      end

      S_RING: begin
        if (stop_req) begin
          state_d = S_CLEAR;
        end else if (bus.snooze_btn && (snooze_count_q < 3'(MAX_SNOOZE))) begin
          state_d        = S_SNOOZE;
          snz_cnt_d      = '0;
          snooze_count_d = snooze_count_q + 3'd1;
        end else if (bus.tick_1hz) begin
          if (ring_cnt_q == RW'(RING_SECONDS - 1)) begin
            state_d = S_CLEAR;
          end else begin
            ring_cnt_d   = ring_cnt_q + RW'(1);
            beep_phase_d = !beep_phase_q;
          end
        end
      end

      S_SNOOZE: begin
        if (stop_req) begin
          state_d = S_CLEAR;
        end else if (bus.tick_1hz) begin
          if (snz_cnt_q == SW'(SNOOZE_SECONDS - 1)) begin
            state_d      = S_RING;
            ring_cnt_d   = '0;
            beep_phase_d = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q + SW'(1);
          end
        end
      end

      S_CLEAR: begin
        if (bus.tick_1hz) begin
          state_d        = S_IDLE;
          snooze_count_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land one cycle after the trigger.
  always_comb begin
    ringing_d  = (state_d == S_RING);
    snoozing_d = (state_d == S_SNOOZE);
    auto_rst_d = (state_d == S_SNOOZE) || (state_d == S_CLEAR);
`ifdef ALARM_ESCALATE_EN
    buzzer_d   = ringing_d && (beep_phase_d || (ring_cnt_d >= RW'(RING_SECONDS / 2)));
`else
    buzzer_d   = ringing_d && beep_phase_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      ring_cnt_q     <= '0;
      snz_cnt_q      <= '0;
      beep_phase_q   <= 1'b0;
      snooze_count_q <= '0;
      buzzer_q       <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
      auto_rst_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      snz_cnt_q      <= snz_cnt_d;
      beep_phase_q   <= beep_phase_d;
      snooze_count_q <= snooze_count_d;
      buzzer_q       <= buzzer_d;
      ringing_q      <= ringing_d;
      snoozing_q     <= snoozing_d;
      auto_rst_q     <= auto_rst_d;
    end
  end

  assign bus.buzzer       = buzzer_q;
  assign bus.ringing      = ringing_q;
  assign bus.snoozing     = snoozing_q;
  assign bus.auto_rst     = auto_rst_q;
  assign bus.snooze_count = snooze_count_q;

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Consumer end of the alarm-match interface: takes the comparator's `on` level, drives the buzzer and snooze logic, and returns `auto_rst` to clear the comparator's latched match.
- Sits between the alarm comparator, the user buttons (already debounced and synchronised), and the buzzer output.
- All timing is counted in seconds using the system 1 Hz tick.

Parameters:
- RING_SECONDS, 60: maximum ring duration in seconds before auto-stop; legal range 2..255.
- SNOOZE_SECONDS, 300: snooze interval in seconds; legal range 1..1023.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event; legal range 0..7.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- tick_1hz, input, 1: one-cycle pulse once per second, synchronous to clk.
- on, input, 1: alarm match level from the comparator; stays latched until auto_rst.
- on_or_off, input, 1: alarm enable switch.
- stop_btn, input, 1: one-cycle stop pulse.
- snooze_btn, input, 1: one-cycle snooze pulse.
- auto_rst, output, 1: clears the comparator latch; level signal.
- buzzer, output, 1: buzzer drive.
- ringing, output, 1: high while in RING.
- snoozing, output, 1: high while in SNOOZE.
- snooze_count, output, 3: snoozes used in the current alarm event.

Behaviour:
- All outputs are registered. Reset values:
  - state = IDLE; buzzer = 0, ringing = 0, snoozing = 0, auto_rst = 0, snooze_count = 0.
  - Internal ring_cnt = 0, snz_cnt = 0, beep_phase = 0.
- Inputs are sampled on the rising edge of clk. Outputs reflect the new state one cycle after the triggering sample.
- Exit priority in every state: !on_or_off > stop_btn > snooze_btn > timeout.
- IDLE:
  - auto_rst = 0.
  - on && on_or_off -> RING, with ring_cnt = 0, beep_phase = 1, snooze_count = 0.
- RING:
  - ringing = 1, auto_rst = 0, buzzer = beep_phase.
  - On each tick_1hz: beep_phase toggles and ring_cnt increments.
  - Exits:
    - !on_or_off or stop_btn -> CLEAR.
    - snooze_btn with snooze_count < MAX_SNOOZE -> SNOOZE, with snz_cnt = 0 and snooze_count + 1.
    - snooze_btn with snooze_count == MAX_SNOOZE is ignored; ringing continues.
    - tick_1hz with ring_cnt == RING_SECONDS-1 -> CLEAR (timeout).
- SNOOZE:
  - snoozing = 1, buzzer = 0, auto_rst = 1 for the whole state, so the comparator does not re-latch.
  - On each tick_1hz: snz_cnt increments.
  - Exits:
    - tick_1hz with snz_cnt == SNOOZE_SECONDS-1 -> RING, with ring_cnt = 0 and beep_phase = 1; snooze_count is kept.
    - stop_btn or !on_or_off -> CLEAR.
    - snooze_btn is ignored.
- CLEAR:
  - auto_rst = 1, buzzer = 0.
  - Stays in CLEAR until the first tick_1hz, then -> IDLE on that edge. This guarantees the time has moved past the match second, so `on` cannot retrigger the same event.
  - snooze_count is zeroed on entry to IDLE.
- Simultaneous events:
  - tick_1hz in the same cycle as stop_btn: stop wins; tick counting in that cycle is discarded.
  - stop_btn and snooze_btn in the same cycle: stop wins.
- on_or_off falling while in IDLE: no action.
- rst_n asserted in any state: immediate asynchronous return to the reset values; buzzer is silenced in the same cycle.
- Counter widths are sized to fit their parameter maximum. Counters never wrap, because every state exits at its terminal count.

Optional Feature:
- ALARM_ESCALATE_EN defined:
  - In RING, once ring_cnt >= RING_SECONDS/2 (integer divide), buzzer = 1 continuously instead of beep_phase.
  - The escalation resets whenever ring_cnt resets (re-entry from SNOOZE).
- ALARM_ESCALATE_EN undefined:
  - buzzer = beep_phase for the whole ring period.

Test Plan:
- Base ring and timeout (RING_SECONDS=4, MAX_SNOOZE=3): raise on with on_or_off=1, then apply 4 ticks.
  - ringing=1 one cycle later.
  - buzzer toggles 1,0,1,0 across the ticks.
  - On the 4th tick: CLEAR with auto_rst=1.
  - Next tick: IDLE with auto_rst=0.
- Snooze cycle (SNOOZE_SECONDS=3): snooze_btn during RING.
  - snoozing=1, auto_rst=1, buzzer=0, snooze_count=1.
  - After 3 ticks: RING again with beep_phase=1.
- Snooze limit (MAX_SNOOZE=2): press snooze 3 times across re-rings.
  - Third press is ignored: ringing stays 1 and snooze_count=2.
- Stop vs snooze: stop_btn and snooze_btn asserted in the same cycle during RING.
  - Required response: CLEAR, snooze_count unchanged, then IDLE after the next tick with snooze_count=0.
- Disable and reset: drop on_or_off during SNOOZE.
  - Required response: CLEAR.
  - Separately, pulse rst_n low mid-RING: buzzer=0 and state IDLE immediately, before any clock edge.
- With ALARM_ESCALATE_EN defined and RING_SECONDS=6:
  - buzzer stays at 1 from the 3rd tick until timeout.
